// File: rtl/uart_cmd_parser.sv
// Purpose : decodes 4-byte host frames (HDR, CMD, ARG, CSUM) from the UART
//           receive stream and drives the trace front-end configuration.
// Latency : CSUM strobe in cycle N -> width/traceEn/rspValid updated in N+2.
// Backpres: one response held in rspValid/rspByte until rspTaken; bytes
//           arriving meanwhile are dropped, so the receiver is never stalled.
//
// Ports
//   clkOut      in   system clock (48 MHz)
//   rst         in   synchronous, active-high reset
//   received    in   one-cycle strobe, rx_byte valid
//   rx_byte     in   [7:0] received byte
//   recv_error  in   one-cycle strobe, framing error on current byte
//   width       out  [2:0] trace bus width (1, 2 or 4)
//   traceEn     out  trace capture enable
//   errCnt      out  [7:0] saturating count of rejected frames
//   rspValid    out  response byte available
//   rspByte     out  [7:0] 8'h06 ACK / 8'h15 NAK
//   rspTaken    in   consumer accepts rspByte this cycle

module uart_cmd_parser #(
  parameter int          DEFAULT_WIDTH = 4,
  parameter int          TIMEOUT       = 48000,
  parameter logic [7:0]  HDR           = 8'hA5
) (
  input  logic       clkOut,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  output logic [2:0] width,
  output logic       traceEn,
  output logic [7:0] errCnt,
  output logic       rspValid,
  output logic [7:0] rspByte,
  input  logic       rspTaken
);

  // Inter-byte timeout counter sizing; TIMEOUT-1 is the last count value
  // before the frame is abandoned.
  localparam int            TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] CMD_WIDTH  = 8'h01;
  localparam logic [7:0] CMD_ENABLE = 8'h02;
  localparam logic [7:0] CMD_PING   = 8'h03;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ARG  = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] toCnt;
  logic [7:0]    cmdReg;
  logic [7:0]    argReg;
  logic [7:0]    csumReg;

  // A byte only counts when no framing error accompanies it.
  logic byteOk;
  assign byteOk = received && !recv_error;

  logic inFrame;
  assign inFrame = (state == S_CMD) || (state == S_ARG) || (state == S_CSUM);

  // Timeout fires only on an idle cycle: a byte arriving on the last count
  // still resets the counter and keeps the frame alive.
  logic timeoutHit;
  assign timeoutHit = inFrame && !received && !recv_error && (toCnt == TO_LAST);

  logic frameAbort;
  assign frameAbort = (inFrame && recv_error) || timeoutHit;

  // ---------------------------------------------------------------------
  // Command decode, evaluated while in EXEC from the latched frame bytes.
  // ---------------------------------------------------------------------
  logic [7:0] frameSum;
  assign frameSum = HDR + cmdReg + argReg + csumReg;

  logic sumOk;
  assign sumOk = (frameSum == 8'h00);

  logic execAck;
  logic execSetWidth;
  logic execSetEn;

  always_comb begin
    execAck      = 1'b0;
    execSetWidth = 1'b0;
    execSetEn    = 1'b0;
    if (sumOk) begin
      case (cmdReg)
        CMD_WIDTH: begin
          if ((argReg == 8'd1) || (argReg == 8'd2) || (argReg == 8'd4)) begin
            execAck      = 1'b1;
            execSetWidth = 1'b1;
          end
        end
        CMD_ENABLE: begin
          execAck   = 1'b1;
          execSetEn = 1'b1;
        end
        CMD_PING: begin
          execAck = 1'b1;
        end
        default: begin
          execAck = 1'b0;
        end
      endcase
    end
  end

  // Rejected frames: NAK from EXEC, framing error or timeout mid-frame.
  logic errInc;
  assign errInc = frameAbort || ((state == S_EXEC) && !execAck);

  // ---------------------------------------------------------------------
  // Frame FSM, byte latches and inter-byte timeout.
  // ---------------------------------------------------------------------
  always_ff @(posedge clkOut) begin
    if (rst) begin
      state   <= S_IDLE;
      toCnt   <= '0;
      cmdReg  <= '0;
      argReg  <= '0;
      csumReg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          toCnt <= '0;
          if (byteOk && (rx_byte == HDR)) begin
            state <= S_CMD;
          end
        end
        S_CMD, S_ARG, S_CSUM: begin
          if (frameAbort) begin
            state <= S_IDLE;
            toCnt <= '0;
          end else if (received) begin
            toCnt <= '0;
            if (state == S_CMD) begin
              cmdReg <= rx_byte;
              state  <= S_ARG;
            end else if (state == S_ARG) begin
              argReg <= rx_byte;
              state  <= S_CSUM;
            end else begin
              csumReg <= rx_byte;
              state   <= S_EXEC;
            end
          end else begin
            toCnt <= toCnt + TW'(1);
          end
        end
        S_EXEC: begin
          state <= S_RESP;
        end
        S_RESP: begin
          // Incoming bytes are dropped here, HDR included.
          if (rspTaken) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          toCnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Configuration, response and error counter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clkOut) begin
    if (rst) begin
      width    <= 3'(DEFAULT_WIDTH);
      traceEn  <= 1'b1;
      errCnt   <= 8'd0;
      rspValid <= 1'b0;
      rspByte  <= 8'd0;
    end else begin
      if (state == S_EXEC) begin
        rspValid <= 1'b1;
        rspByte  <= execAck ? ACK : NAK;
        if (execSetWidth) begin
          width <= argReg[2:0];
        end
        if (execSetEn) begin
          traceEn <= argReg[0];
        end
      end else if ((state == S_RESP) && rspTaken) begin
        // rspByte keeps its last value; only the valid flag drops.
        rspValid <= 1'b0;
      end

      if (errInc && (errCnt != 8'hFF)) begin
        errCnt <= errCnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

  logic       clkOut = 1'b0;
  logic       rst;
  logic       received;
  logic [7:0] rx_byte;
  logic       recv_error;
  logic [2:0] width;
  logic       traceEn;
  logic [7:0] errCnt;
  logic       rspValid;
  logic [7:0] rspByte;
  logic       rspTaken;

  always #10 clkOut = ~clkOut;

  uart_cmd_parser #(
    .DEFAULT_WIDTH(4),
    .TIMEOUT(48000),
    .HDR(8'hA5)
  ) dut (
    .clkOut(clkOut),
    .rst(rst),
    .received(received),
    .rx_byte(rx_byte),
    .recv_error(recv_error),
    .width(width),
    .traceEn(traceEn),
    .errCnt(errCnt),
    .rspValid(rspValid),
    .rspByte(rspByte),
    .rspTaken(rspTaken)
  );

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  // Reference model: configuration and error count as the host sees them.
  int         mWidth;
  int         mEn;
  int         mErr;
  logic [7:0] expRsp;

  task automatic tick();
    @(posedge clkOut);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mWidth = 4;
    mEn    = 1;
    mErr   = 0;
  endtask

  task automatic modelBumpErr();
    if (mErr < 255) mErr++;
  endtask

  // Frame semantics straight from the command table.
  task automatic modelExec(input int cmd, input int arg, input int csum, output bit ack);
    ack = 1'b0;
    if (((165 + cmd + arg + csum) % 256) == 0) begin
      if (cmd == 1 && (arg == 1 || arg == 2 || arg == 4)) begin
        mWidth = arg;
        ack    = 1'b1;
      end else if (cmd == 2) begin
        mEn = arg % 2;
        ack = 1'b1;
      end else if (cmd == 3) begin
        ack = 1'b1;
      end
    end
    if (!ack) modelBumpErr();
    expRsp = ack ? 8'h06 : 8'h15;
  endtask

  function automatic int goodSum(input int cmd, input int arg);
    return (1024 - 165 - cmd - arg) % 256;
  endfunction

  // Drives one byte for one cycle; returns in the following cycle.
  task automatic sendByte(input logic [7:0] b);
    rx_byte  = b;
    received = 1'b1;
    tick();
    received = 1'b0;
  endtask

  task automatic frameBytes(input int cmd, input int arg, input int csum, input int gapMax);
    sendByte(8'hA5);
    repeat ($urandom_range(0, gapMax)) tick();
    sendByte(8'(cmd));
    repeat ($urandom_range(0, gapMax)) tick();
    sendByte(8'(arg));
    repeat ($urandom_range(0, gapMax)) tick();
    sendByte(8'(csum));
  endtask

  // Called in cycle N+1 after the CSUM strobe; checks N+1 and N+2.
  task automatic expectResult(input string tag, input int cmd, input int arg, input int csum);
    bit ack;
    modelExec(cmd, arg, csum, ack);
    check({tag, ".n1.vld"}, 32'(rspValid), 0);
    tick();
    check({tag, ".vld"},    32'(rspValid), 1);
    check({tag, ".byte"},   32'(rspByte),  32'(expRsp));
    check({tag, ".width"},  32'(width),    32'(mWidth));
    check({tag, ".en"},     32'(traceEn),  32'(mEn));
    check({tag, ".err"},    32'(errCnt),   32'(mErr));
  endtask

  task automatic releaseRsp(input string tag, input int hold);
    repeat (hold) tick();
    check({tag, ".hold.vld"},  32'(rspValid), 1);
    check({tag, ".hold.byte"}, 32'(rspByte),  32'(expRsp));
    rspTaken = 1'b1;
    tick();
    rspTaken = 1'b0;
    check({tag, ".clr"}, 32'(rspValid), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelReset();
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, ".width"}, 32'(width),    4);
    check({tag, ".en"},    32'(traceEn),  1);
    check({tag, ".err"},   32'(errCnt),   0);
    check({tag, ".vld"},   32'(rspValid), 0);
    check({tag, ".byte"},  32'(rspByte),  0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         sawRsp;
    int         cmd;
    int         arg;
    int         csum;
    int         sel;
    logic [7:0] noise;
    logic [7:0] heldByte;

    rst        = 1'b1;
    received   = 1'b0;
    rx_byte    = 8'h00;
    recv_error = 1'b0;
    rspTaken   = 1'b0;
    modelReset();
    repeat (3) tick();
    checkResetVals("rst");
    rst = 1'b0;
    tick();

    // Set width to 2; response taken at N+5, cleared at N+6.
    frameBytes(1, 2, 8'h58, 0);
    expectResult("t1", 1, 2, 8'h58);
    check("t1.width2", 32'(width), 2);
    releaseRsp("t1", 3);

    // Valid checksum but illegal width.
    doReset();
    frameBytes(1, 3, 8'h57, 2);
    expectResult("t2", 1, 3, 8'h57);
    check("t2.width4", 32'(width), 4);
    check("t2.err1", 32'(errCnt), 1);
    releaseRsp("t2", 1);

    // Disable trace, then a ping preceded by a noise byte.
    frameBytes(2, 0, 8'h59, 1);
    expectResult("t3a", 2, 0, 8'h59);
    check("t3a.en0", 32'(traceEn), 0);
    releaseRsp("t3a", 0);
    sendByte(8'h00);
    frameBytes(3, 0, 8'h58, 1);
    expectResult("t3b", 3, 0, 8'h58);
    releaseRsp("t3b", 2);

    // Inter-byte timeout after HDR, CMD.
    doReset();
    sawRsp = 1'b0;
    sendByte(8'hA5);
    sendByte(8'h01);
    for (int i = 0; i < 47990; i++) begin
      tick();
      sawRsp |= rspValid;
    end
    check("t4.noEarly", 32'(errCnt), 32'(mErr));
    for (int i = 0; i < 15; i++) begin
      tick();
      sawRsp |= rspValid;
    end
    modelBumpErr();
    check("t4.err", 32'(errCnt), 32'(mErr));
    check("t4.noRsp", 32'(sawRsp), 0);
    frameBytes(3, 0, 8'h58, 0);
    expectResult("t4b", 3, 0, 8'h58);
    releaseRsp("t4b", 0);

    // Framing error together with the ARG byte.
    sendByte(8'hA5);
    sendByte(8'h01);
    rx_byte    = 8'h02;
    received   = 1'b1;
    recv_error = 1'b1;
    tick();
    received   = 1'b0;
    recv_error = 1'b0;
    modelBumpErr();
    check("t5.err", 32'(errCnt), 32'(mErr));
    sendByte(8'h58);
    tick();
    tick();
    check("t5.noRsp", 32'(rspValid), 0);
    frameBytes(1, 1, goodSum(1, 1), 2);
    expectResult("t5b", 1, 1, goodSum(1, 1));
    releaseRsp("t5b", 0);

    // HDR with framing error in IDLE is discarded; error alone ignored.
    rx_byte    = 8'hA5;
    received   = 1'b1;
    recv_error = 1'b1;
    tick();
    received   = 1'b0;
    recv_error = 1'b0;
    sendByte(8'h03);
    sendByte(8'h00);
    sendByte(8'h58);
    tick();
    tick();
    check("idleErr.noRsp", 32'(rspValid), 0);
    check("idleErr.err", 32'(errCnt), 32'(mErr));

    // A full frame while a response is pending is discarded.
    frameBytes(3, 0, 8'h58, 0);
    expectResult("t6a", 3, 0, 8'h58);
    heldByte = rspByte;
    frameBytes(1, 4, goodSum(1, 4), 3);
    recv_error = 1'b1;
    tick();
    recv_error = 1'b0;
    repeat (85) tick();
    check("t6a.stable", 32'(rspByte), 32'(heldByte));
    releaseRsp("t6a", 0);
    check("t6a.width", 32'(width), 32'(mWidth));
    check("t6a.err", 32'(errCnt), 32'(mErr));
    repeat (3) tick();
    check("t6a.noRsp", 32'(rspValid), 0);
    rspTaken = 1'b1;
    tick();
    rspTaken = 1'b0;
    check("t6a.idleTaken", 32'(rspValid), 0);

    // Bad-checksum frames until the error counter saturates.
    for (int i = 0; i < 300; i++) begin
      frameBytes(3, i % 256, (goodSum(3, i % 256) + 1) % 256, 0);
      expectResult("t6b", 3, i % 256, (goodSum(3, i % 256) + 1) % 256);
      releaseRsp("t6b", 0);
    end
    check("t6b.sat", 32'(errCnt), 255);

    // Randomised frames against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        noise = 8'($urandom_range(0, 255));
        if (noise == 8'hA5) noise = 8'h5A;
        sendByte(noise);
      end
      sel = $urandom_range(0, 4);
      case (sel)
        0: cmd = 1;
        1: cmd = 2;
        2: cmd = 3;
        3: cmd = 1;
        default: cmd = $urandom_range(0, 255);
      endcase
      if (cmd == 1) begin
        sel = $urandom_range(0, 6);
        case (sel)
          0: arg = 1;
          1: arg = 2;
          2: arg = 4;
          3: arg = 0;
          4: arg = 3;
          5: arg = 8;
          default: arg = $urandom_range(0, 255);
        endcase
      end else begin
        arg = $urandom_range(0, 255);
      end
      csum = goodSum(cmd, arg);
      if ($urandom_range(0, 3) == 0) csum = (csum + $urandom_range(1, 255)) % 256;
      frameBytes(cmd, arg, csum, 3);
      expectResult("rnd", cmd, arg, csum);
      releaseRsp("rnd", $urandom_range(0, 5));
    end

    // Reset while in ARG.
    frameBytes(1, 2, 8'h58, 0);
    expectResult("pre", 1, 2, 8'h58);
    releaseRsp("pre", 0);
    sendByte(8'hA5);
    sendByte(8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkResetVals("rstArg");

    // Reset with a response pending drops it.
    frameBytes(2, 0, 8'h59, 0);
    expectResult("pend", 2, 0, 8'h59);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkResetVals("rstResp");
    frameBytes(3, 0, 8'h58, 1);
    expectResult("post", 3, 0, 8'h58);
    releaseRsp("post", 1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
